// File: rtl/add16_sched_if.sv
// Request/response bundle for the shared 16-bit adder scheduler.
// The rsp_carry signal exists only when ADD16_SCHED_CARRY_EN is defined.
interface add16_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
`ifdef ADD16_SCHED_CARRY_EN
    logic             rsp_carry;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
`ifdef ADD16_SCHED_CARRY_EN
        , input rsp_carry
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
`ifdef ADD16_SCHED_CARRY_EN
        , output rsp_carry
`endif
    );
endinterface

// File: rtl/add16_sched.sv
// Round-robin scheduler sharing one adder between two requesters, one registered result.
// Define ADD16_SCHED_CARRY_EN to add the registered rsp_carry output.
module add16_sched #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    add16_sched_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

    logic             any_valid;
    logic             grant;
    logic             owner_rsp_ready;
    logic             fire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef ADD16_SCHED_CARRY_EN
    logic             rsp_carry_q;
    logic [WIDTH:0]   sum;
`else
    logic [WIDTH-1:0] sum;
`endif

    // A new op is taken when idle, or when the owner drains its result this same
    // cycle; gating with reset keeps an in-flight request from seeing acceptance.
    // NOTE: every signal gets a value at the top of always_comb, so no latch can form.
    always_comb begin
        any_valid       = bus.req0_valid | bus.req1_valid;
        grant           = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;
        fire            = !reset && any_valid && (state == IDLE || owner_rsp_ready);
        op_a            = grant ? bus.req1_a : bus.req0_a;
        op_b            = grant ? bus.req1_b : bus.req0_b;
`ifdef ADD16_SCHED_CARRY_EN
        sum             = {1'b0, op_a} + {1'b0, op_b};
`else
        sum             = op_a + op_b;
`endif
    end

    assign bus.req0_ready = fire && !grant;
    assign bus.req1_ready = fire && grant;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_data   = rsp_data_q;
`ifdef ADD16_SCHED_CARRY_EN
    assign bus.rsp_carry  = rsp_carry_q;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
`ifdef ADD16_SCHED_CARRY_EN
            rsp_carry_q  <= 1'b0;
`endif
        end else if (fire) begin
            state        <= RESP;
            owner        <= grant;
            last_grant   <= grant;
            rsp0_valid_q <= !grant;
            rsp1_valid_q <= grant;
            rsp_data_q   <= sum[WIDTH-1:0];
`ifdef ADD16_SCHED_CARRY_EN
            rsp_carry_q  <= sum[WIDTH];
`endif
        end else if (state == RESP && owner_rsp_ready) begin
            state        <= IDLE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add16_sched.sv
// Self-checking bench for add16_sched: scenario tasks plus a scoreboard that
// compares each result at the cycle its owner consumes it.
module tb_add16_sched;
    logic clk;
    logic reset;

    add16_sched_if #(.WIDTH(16)) bus ();

    add16_sched #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;
        logic [15:0] data;
        logic        carry;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;
    logic lg     = 1'b1;   // bench model of the arbiter's last grant

    // Scoreboard: a result is compared when its owner takes it.
    always @(negedge clk) begin
        if (!reset && ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready))) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: rsp0_valid=%b rsp1_valid=%b data=%h with nothing expected",
                         bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus.rsp1_valid !== mon_e.owner || bus.rsp0_valid !== !mon_e.owner || bus.rsp_data !== mon_e.data)
                    $display("FAIL sb_result: got owner1=%b owner0=%b data=%h, expected owner=%0d data=%h",
                             bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, mon_e.owner, mon_e.data);
                else passed++;
`ifdef ADD16_SCHED_CARRY_EN
                total++;
                if (bus.rsp_carry !== mon_e.carry)
                    $display("FAIL sb_carry: got %b expected %b", bus.rsp_carry, mon_e.carry);
                else passed++;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        lg    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0000 || bus.rsp_data !== 16'h0000)
                $display("FAIL reset_idle[%0d]: rsp_v=%b%b req_rdy=%b%b data=%h, expected all 0",
                         i, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready, bus.rsp_data);
            else passed++;
            tick();
        end
    endtask

    task automatic test_single();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h0001;
        sb.push_back('{1'b0, 16'h1235, 1'b0});
        lg = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL single_accept: req_rdy=%b%b expected 10", bus.req0_ready, bus.req1_ready);
        else passed++;
        tick();
        bus.req0_valid = 1'b0; bus.rsp0_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 16'h1235)
            $display("FAIL single_rsp: rsp_v=%b%b data=%h expected 10 1235", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
        else passed++;
        tick();
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0)
            $display("FAIL single_drop: rsp_v=%b%b expected 00", bus.rsp0_valid, bus.rsp1_valid);
        else passed++;
        tick();
    endtask

    task automatic test_wrap();
        bus.req1_valid = 1'b1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0002;
        sb.push_back('{1'b1, 16'h0001, 1'b1});
        lg = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0)
            $display("FAIL wrap_accept: req_rdy=%b%b expected 01", bus.req0_ready, bus.req1_ready);
        else passed++;
        tick();
        // Owner drains while requester 0 asks: accepted in the same cycle.
        bus.req1_valid = 1'b0; bus.rsp1_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001;
        sb.push_back('{1'b0, 16'h8000, 1'b0});
        lg = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== 16'h0001 || bus.req0_ready !== 1'b1)
            $display("FAIL wrap_rsp: rsp1_v=%b data=%h req0_rdy=%b expected 1 0001 1",
                     bus.rsp1_valid, bus.rsp_data, bus.req0_ready);
        else passed++;
        tick();
        bus.req0_valid = 1'b0; bus.rsp1_ready = 1'b0; bus.rsp0_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 16'h8000)
            $display("FAIL wrap_b2b: rsp_v=%b%b data=%h expected 10 8000", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
        else passed++;
        tick();
        bus.rsp0_ready = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic g;
        logic prev = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'd1;  bus.req0_b = 16'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 16'd10; bus.req1_b = 16'd10;
        for (int i = 0; i < 6; i++) begin
            g = ~lg;
            sb.push_back('{g, g ? 16'd20 : 16'd2, 1'b0});
            @(negedge clk);
            total++;
            if (bus.req0_ready !== !g || bus.req1_ready !== g)
                $display("FAIL contention_grant[%0d]: req_rdy=%b%b expected grant %0d", i, bus.req0_ready, bus.req1_ready, g);
            else passed++;
            if (i > 0) begin
                total++;
                if (bus.rsp1_valid !== prev || bus.rsp0_valid !== !prev || bus.rsp_data !== (prev ? 16'd20 : 16'd2))
                    $display("FAIL contention_rsp[%0d]: rsp_v=%b%b data=%h expected owner %0d", i,
                             bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, prev);
                else passed++;
            end
            lg   = g;
            prev = g;
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp1_valid !== prev || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
            $display("FAIL contention_tail: rsp1_v=%b req_rdy=%b%b expected %b 00",
                     bus.rsp1_valid, bus.req0_ready, bus.req1_ready, prev);
        else passed++;
        tick();
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bus.rsp1_ready = 1'b1;   // non-owner ready must have no effect
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0100; bus.req0_b = 16'h0023;
        sb.push_back('{1'b0, 16'h0123, 1'b0});
        lg = 1'b0;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h4000; bus.req1_b = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 16'h0123 || bus.req1_ready !== 1'b0)
                $display("FAIL backpressure_hold[%0d]: rsp0_v=%b data=%h req1_rdy=%b expected 1 0123 0",
                         i, bus.rsp0_valid, bus.rsp_data, bus.req1_ready);
            else passed++;
            tick();
        end
        bus.rsp0_ready = 1'b1;
        sb.push_back('{1'b1, 16'h4004, 1'b0});
        lg = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req1_ready !== 1'b1)
            $display("FAIL backpressure_release: req1_rdy=%b expected 1", bus.req1_ready);
        else passed++;
        tick();
        bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 16'h4004)
            $display("FAIL backpressure_next: rsp_v=%b%b data=%h expected 01 4004", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
        else passed++;
        tick();
        bus.rsp1_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0006;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0003; bus.req1_b = 16'h0004;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL resetmid_pre: rsp0_v=%b req1_rdy=%b expected 1 0", bus.rsp0_valid, bus.req1_ready);
        else passed++;
        tick();
        reset = 1'b0;
        lg    = 1'b1;       // pending req0 result discarded: nothing queued
        bus.req0_valid = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 16'h0000)
            $display("FAIL resetmid_clear: rsp_v=%b%b data=%h expected 00 0000", bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
        else passed++;
`ifdef ADD16_SCHED_CARRY_EN
        total++;
        if (bus.rsp_carry !== 1'b0) $display("FAIL resetmid_carry: got %b expected 0", bus.rsp_carry);
        else passed++;
`endif
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL resetmid_arb: req_rdy=%b%b expected 10", bus.req0_ready, bus.req1_ready);
        else passed++;
        sb.push_back('{1'b0, 16'h000B, 1'b0});
        tick();
        bus.req0_valid = 1'b0; bus.rsp0_ready = 1'b1;
        sb.push_back('{1'b1, 16'h0007, 1'b0});
        @(negedge clk);
        total++;
        if (bus.req1_ready !== 1'b1)
            $display("FAIL resetmid_b2b: req1_rdy=%b expected 1", bus.req1_ready);
        else passed++;
        tick();
        bus.req1_valid = 1'b0; bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
        tick();
        bus.rsp1_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0)
            $display("FAIL resetmid_idle: rsp_v=%b%b expected 00", bus.rsp0_valid, bus.rsp1_valid);
        else passed++;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_backpressure();
        test_reset_mid();

        total++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d results never delivered, expected 0", sb.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
